// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// default operand width and the iteration-counter width helper.
package seq_divider32_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_t;

   localparam int DIV_WIDTH = 32;

   // Counter must hold WIDTH-1 down to 0
   function automatic int div_cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/seq_divider32_addsub.sv
// Ripple-carry add/subtract built from a one-bit full-adder cell.
// sub=1 computes a - b as a + ~b + 1.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_n #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] s,
   output logic         cout
);
   logic [N:0]   carry;
   logic [N-1:0] b_x;

   assign carry[0] = sub;
   assign b_x      = b ^ {N{sub}};
   assign cout     = carry[N];

   // One full-adder cell per bit, carry rippling upward
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
         fulladder u_fa (
            .a   (a[gi]),
            .b   (b_x[gi]),
            .cin (carry[gi]),
            .s   (s[gi]),
            .cout(carry[gi+1])
         );
      end
   endgenerate
endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle non-restoring divider: one quotient bit per clock through a
// WIDTH+1 add/sub stage, sign fix-up in a final cycle, one-cycle done pulse.
module seq_divider32
   import seq_divider32_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dz,
   output logic             ovf
);
   localparam int CNT_W = div_cnt_w(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH:0]   p_reg;
   logic [WIDTH-1:0] q_reg, d_reg;
   logic             sign_q_reg, sign_r_reg, ovf_pend_reg;
   logic [WIDTH-1:0] quotient_reg, remainder_reg;
   logic             dz_reg, ovf_reg, done_reg;

   logic             accept, as_fix, as_sub;
   logic [WIDTH:0]   as_a, as_sum;
   logic [WIDTH-1:0] neg_dvd, neg_dvs, neg_q, neg_r, mag_dvd, mag_dvs, rem_mag;
   logic             unused_step_cout, unused_nd_cout, unused_ns_cout;
   logic             unused_nq_cout, unused_nr_cout;

   // A start landing in the done cycle is dropped, so accept is gated by done
   assign accept = (state_reg == S_IDLE) && start && !done_reg;

   // Main iteration stage: shift-and-add/sub in RUN, restoring add in FIX
   assign as_a = as_fix ? p_reg : {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   addsub_n #(.N(WIDTH+1)) u_step (
      .a(as_a), .b({1'b0, d_reg}), .sub(as_sub), .s(as_sum), .cout(unused_step_cout)
   );

   // Operand magnitudes on accept (MIN negates to itself and reads as unsigned)
   addsub_n #(.N(WIDTH)) u_neg_dvd (
      .a('0), .b(dividend), .sub(1'b1), .s(neg_dvd), .cout(unused_nd_cout)
   );
   addsub_n #(.N(WIDTH)) u_neg_dvs (
      .a('0), .b(divisor), .sub(1'b1), .s(neg_dvs), .cout(unused_ns_cout)
   );
   assign mag_dvd = (signed_op && dividend[WIDTH-1]) ? neg_dvd : dividend;
   assign mag_dvs = (signed_op && divisor[WIDTH-1])  ? neg_dvs : divisor;

   // Sign fix-up of the final quotient and corrected remainder
   assign rem_mag = p_reg[WIDTH] ? as_sum[WIDTH-1:0] : p_reg[WIDTH-1:0];
   addsub_n #(.N(WIDTH)) u_neg_q (
      .a('0), .b(q_reg), .sub(1'b1), .s(neg_q), .cout(unused_nq_cout)
   );
   addsub_n #(.N(WIDTH)) u_neg_r (
      .a('0), .b(rem_mag), .sub(1'b1), .s(neg_r), .cout(unused_nr_cout)
   );

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (accept) state_next = (divisor == '0) ? S_DONE : S_RUN;
         S_RUN:   if (cnt_reg == '0) state_next = S_FIX;
         S_FIX:   state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State-decoded outputs and datapath controls
   always_comb begin
      busy   = (state_reg == S_RUN) || (state_reg == S_FIX);
      as_fix = (state_reg == S_FIX);
      as_sub = (state_reg == S_RUN) && !p_reg[WIDTH];
   end

   // State register, iteration datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         p_reg         <= '0;
         q_reg         <= '0;
         d_reg         <= '0;
         sign_q_reg    <= 1'b0;
         sign_r_reg    <= 1'b0;
         ovf_pend_reg  <= 1'b0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dz_reg        <= 1'b0;
         ovf_reg       <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               done_reg <= 1'b0;
               if (accept) begin
                  sign_q_reg   <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  sign_r_reg   <= signed_op && dividend[WIDTH-1];
                  d_reg        <= mag_dvs;
                  // Divide-by-zero keeps the raw dividend for the remainder
                  q_reg        <= (divisor == '0) ? dividend : mag_dvd;
                  p_reg        <= '0;
                  cnt_reg      <= CNT_W'(WIDTH-1);
                  ovf_pend_reg <= signed_op && (dividend == MIN_VAL) && (divisor == '1);
                  dz_reg       <= 1'b0;
                  ovf_reg      <= 1'b0;
               end
            end
            S_RUN: begin
               p_reg   <= as_sum;
               q_reg   <= {q_reg[WIDTH-2:0], ~as_sum[WIDTH]};
               cnt_reg <= cnt_reg - CNT_W'(1);
            end
            S_FIX: begin
               quotient_reg  <= sign_q_reg ? neg_q : q_reg;
               remainder_reg <= sign_r_reg ? neg_r : rem_mag;
               ovf_reg       <= ovf_pend_reg;
               dz_reg        <= 1'b0;
               done_reg      <= 1'b1;
            end
            S_DONE: begin
               // Entered straight from IDLE only on divide-by-zero
               if (!done_reg) begin
                  quotient_reg  <= '1;
                  remainder_reg <= q_reg;
                  dz_reg        <= 1'b1;
                  ovf_reg       <= 1'b0;
                  done_reg      <= 1'b1;
               end else begin
                  done_reg <= 1'b0;
               end
            end
            default: done_reg <= 1'b0;
         endcase
      end
   end

   assign done      = done_reg;
   assign quotient  = quotient_reg;
   assign remainder = remainder_reg;
   assign dz        = dz_reg;
   assign ovf       = ovf_reg;
endmodule
